// File: rtl/priority_decoder_seq.sv
// Buffers priority codes in a small FIFO and replays each as a one-hot word
// held for a programmable number of cycles.
module priority_decoder_seq #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CODE_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [3:0]        hold_len,
    input  logic              err_clr,
    output logic [15:0]       onehot_out,
    output logic              busy,
    output logic [2:0]        fifo_count,
    output logic              err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [2:0]         r_count;
    logic [3:0]         r_timer;
    logic [3:0]         w_timer_nxt;
    logic [15:0]        r_onehot;
    logic [15:0]        w_onehot_nxt;
    logic               r_err;
    logic [4:0]         r_mem [FIFO_DEPTH];

    logic               w_is_idx;
    logic               w_is_noreq;
    logic               w_accept;
    logic               w_push;
    logic               w_bad;
    logic               w_pop;
    logic [4:0]         w_entry;
    logic [4:0]         w_head;
    logic [15:0]        w_head_onehot;
    logic [3:0]         w_hold_load;

    assign w_is_idx    = (code_in < CODE_W'(16));
    assign w_is_noreq  = (code_in == CODE_W'(8'hF0));
    assign w_accept    = code_valid && code_ready;
    assign w_push      = w_accept && (w_is_idx || w_is_noreq);
    assign w_bad       = w_accept && !(w_is_idx || w_is_noreq);
    // Entry layout: bit 4 marks the "no request" code, bits 3:0 carry the index.
    assign w_entry     = {w_is_noreq, code_in[3:0]};
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_onehot = w_head[4] ? '0 : (16'(1) << w_head[3:0]);
    assign w_hold_load = (hold_len == 4'd0) ? 4'd1 : hold_len;

    assign code_ready  = (r_count < 3'(FIFO_DEPTH));
    assign fifo_count  = r_count;
    assign onehot_out  = r_onehot;
    assign busy        = (r_state == HOLD);
    assign err         = r_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_onehot_nxt = r_onehot;
        w_timer_nxt  = r_timer;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != 3'd0) begin
                    w_pop        = 1'b1;
                    w_state_nxt  = HOLD;
                    w_onehot_nxt = w_head_onehot;
                    w_timer_nxt  = w_hold_load;
                end else begin
                    w_onehot_nxt = '0;
                end
            end
            HOLD: begin
                if (r_timer > 4'd1) begin
                    w_timer_nxt = r_timer - 4'd1;
                end else if (r_count != 3'd0) begin
                    w_pop        = 1'b1;
                    w_onehot_nxt = w_head_onehot;
                    w_timer_nxt  = w_hold_load;
                end else begin
                    w_state_nxt  = IDLE;
                    w_onehot_nxt = '0;
                    w_timer_nxt  = 4'd0;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_onehot_nxt = '0;
                w_timer_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_onehot <= '0;
            r_timer  <= 4'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 3'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_onehot <= w_onehot_nxt;
            r_timer  <= w_timer_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            // Set has priority over clear.
            if (w_bad)        r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

endmodule
